// File: rtl/alu_exec_unit_if.sv
// Request/result bus of the EX-stage execution unit.
// master: pipeline side that issues operations; slave: the unit itself.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            ready_out;
    logic            flush_in;
    logic [XLEN-1:0] pc_ex;
    logic [XLEN-1:0] reg_1_in;
    logic [XLEN-1:0] reg_2_in;
    logic [XLEN-1:0] imm_data_in;
    logic [1:0]      alu_mode_select;
    logic [4:0]      alu_op;
    logic            result_valid_out;
    logic [XLEN-1:0] alu_result_out;
    logic            alu_zero_out;
    logic            busy_out;

    modport master (
        output valid_in, flush_in, pc_ex, reg_1_in, reg_2_in, imm_data_in,
               alu_mode_select, alu_op,
        input  ready_out, result_valid_out, alu_result_out, alu_zero_out, busy_out
    );

    modport slave (
        input  valid_in, flush_in, pc_ex, reg_1_in, reg_2_in, imm_data_in,
               alu_mode_select, alu_op,
        output ready_out, result_valid_out, alu_result_out, alu_zero_out, busy_out
    );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle base integer ops, iterative RV32M
// multiply/divide behind a valid/ready handshake with flush.
// Optional macro ALU_MEXT_EN enables the multiply/divide datapath and BUSY
// state; without it, codes 16-23 are illegal and the unit is always ready.
module alu_exec_unit #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    alu_exec_unit_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_PASSB = 5'd10;

    logic [XLEN-1:0] op_a, op_b, base_res, res_d;
    logic [XLEN-1:0] res_q;
    logic            zero_q, vld_q;
    logic            accept, load_base, load_m;

    // operand select; sampled only on the accept edge
    always_comb begin
        op_a = bus.reg_1_in;
        op_b = bus.reg_2_in;
        case (bus.alu_mode_select)
            2'd0: ;
            2'd1: op_b = bus.imm_data_in;
            2'd2: begin
                op_a = bus.pc_ex;
                op_b = bus.imm_data_in;
            end
            default: begin
                op_a = bus.pc_ex;
                op_b = XLEN'(4);
            end
        endcase
    end

    // single-cycle base ops; anything not listed (incl. M codes here) yields 0
    always_comb begin
        base_res = '0;
        case (bus.alu_op)
            OP_ADD:   base_res = op_a + op_b;
            OP_SUB:   base_res = op_a - op_b;
            OP_SLL:   base_res = op_a << op_b[SH_W-1:0];
            OP_SLT:   base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:   base_res = op_a ^ op_b;
            OP_SRL:   base_res = op_a >> op_b[SH_W-1:0];
            OP_SRA:   base_res = $signed(op_a) >>> op_b[SH_W-1:0];
            OP_OR:    base_res = op_a | op_b;
            OP_AND:   base_res = op_a & op_b;
            OP_PASSB: base_res = op_b;
            default:  base_res = '0;
        endcase
    end

    assign accept = bus.valid_in & bus.ready_out & ~bus.flush_in;

`ifdef ALU_MEXT_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*XLEN-1:0]   acc_q, acc_step, prod;
    logic [XLEN-1:0]     b_q, a_mag, b_mag, quo, rem, m_res;
    logic [2:0]          mop_q;
    logic                neg_q, rneg_q, div0_q;
    logic                is_mop, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN:0]       mul_sum, div_tmp, div_sub;
    logic                div_ge;

    assign is_mop        = (bus.alu_op[4:3] == 2'b10);
    assign bus.ready_out = (state_q == IDLE);
    assign bus.busy_out  = (state_q == BUSY);
    assign load_base     = accept & ~is_mop;
    assign load_m        = (state_q == BUSY) & (cnt_q == CNT_W'(1)) & ~bus.flush_in;
    assign res_d         = load_m ? m_res : base_res;

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // FSM next state; flush overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_mop) state_d = BUSY;
            BUSY:    if (cnt_q == CNT_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush_in) state_d = IDLE;
    end

    // iteration counter runs XLEN..1 while busy, clears on flush
    always_ff @(posedge clk_in) begin
        if (!rst_n_in)              cnt_q <= '0;
        else if (bus.flush_in)      cnt_q <= '0;
        else if (accept && is_mop)  cnt_q <= CNT_W'(XLEN);
        else if (state_q == BUSY)   cnt_q <= cnt_q - CNT_W'(1);
    end

    // operand signedness per M code (low 3 bits of the opcode)
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (bus.alu_op[2:0])
            3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'd2:             a_sgn = 1'b1;
            default:          ;
        endcase
    end

    assign a_neg = a_sgn & op_a[XLEN-1];
    assign b_neg = b_sgn & op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // latch magnitudes at accept, then one shift-add / restoring step per cycle.
    // acc holds {partial product | remainder, multiplier | quotient}.
    always_ff @(posedge clk_in) begin
        if (accept && is_mop) begin
            acc_q  <= {{XLEN{1'b0}}, a_mag};
            b_q    <= b_mag;
            mop_q  <= bus.alu_op[2:0];
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            div0_q <= (op_b == '0);
        end else if (state_q == BUSY) begin
            acc_q  <= acc_step;
        end
    end

    // one iteration of the selected algorithm
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_tmp = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_sub = div_tmp - {1'b0, b_q};
        div_ge  = (div_tmp >= {1'b0, b_q});
        if (mop_q[2])
            acc_step = {(div_ge ? div_sub[XLEN-1:0] : div_tmp[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
        else
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end

    // sign fixup on the final step; x/0 forces an all-ones quotient, and the
    // remainder of x/0 naturally comes out as x after the dividend-sign fixup
    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quo  = div0_q ? '1 : (neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0]);
        rem  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (mop_q)
            3'd0:             m_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: m_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       m_res = quo;
            default:          m_res = rem;
        endcase
    end
`else
    assign bus.ready_out = 1'b1;
    assign bus.busy_out  = 1'b0;
    assign load_base     = accept;
    assign load_m        = 1'b0;
    assign res_d         = base_res;
`endif

    // result/zero registers and the one-cycle completion pulse
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (load_base || load_m) begin
                res_q  <= res_d;
                zero_q <= (res_d == '0);
                vld_q  <= 1'b1;
            end
        end
    end

    // a flush arriving in the pulse cycle swallows the pulse
    assign bus.result_valid_out = vld_q & ~bus.flush_in;
    assign bus.alu_result_out   = res_q;
    assign bus.alu_zero_out     = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table driven through a
// scoreboard, plus hand sequences for back-to-back, busy length, flush, reset.
// Expectations follow ALU_MEXT_EN the same way the design does.
module tb_alu_exec_unit;
`ifdef ALU_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif
    localparam int XLEN = 32;

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  mode;
        logic [31:0] r1, r2, imm, pc;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_res = '0;
    vec_t tv[$];
    sb_t  sbq[$];

    alu_exec_unit_if #(.XLEN(XLEN)) bus();

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void add(input logic [4:0] op, input logic [1:0] mode,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [31:0] exp);
        vec_t v;
        v.op = op; v.mode = mode; v.r1 = r1; v.r2 = r2; v.imm = imm; v.pc = pc;
        v.exp = exp;
        tv.push_back(v);
    endfunction

    // M ops collapse to illegal (0) when the extension is absent
    function automatic void addm(input logic [4:0] op, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] exp);
        add(op, 2'd0, r1, r2, 32'h0, 32'h0, MEXT ? exp : 32'h0);
    endfunction

    function automatic bit is_m(input logic [4:0] op);
        return MEXT && (op >= 5'd16) && (op <= 5'd23);
    endfunction

    // scoreboard check on every completion pulse
    always @(negedge clk) begin
        if (bus.result_valid_out) begin
            sb_t e;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: result_valid_out=1 with nothing pending, result %h",
                         bus.alu_result_out);
            end else begin
                e = sbq.pop_front();
                chk("result", bus.alu_result_out, e.res);
                chk("zero", 32'(bus.alu_zero_out), 32'(e.res == 32'h0));
                chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                last_res = e.res;
            end
        end
    end

    // called at posedge+1; waits for ready, presents one request, returns at
    // posedge+1 of the cycle after the accept edge with valid dropped
    task automatic send(input vec_t v, input bit push);
        sb_t e;
        int  budget = 200;
        while (!bus.ready_out && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!bus.ready_out) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready_out stayed 0, expected 1");
            return;
        end
        bus.alu_op          = v.op;
        bus.alu_mode_select = v.mode;
        bus.reg_1_in        = v.r1;
        bus.reg_2_in        = v.r2;
        bus.imm_data_in     = v.imm;
        bus.pc_ex           = v.pc;
        bus.valid_in        = 1'b1;
        if (push) begin
            e.res     = v.exp;
            e.acc_cyc = cyc;
            e.lat     = is_m(v.op) ? XLEN + 1 : 1;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic drain();
        int budget = 200;
        while (sbq.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.mode = 2'd0; v.r1 = r1; v.r2 = r2; v.imm = '0; v.pc = '0;
        v.exp = exp;
        return v;
    endfunction

    initial begin
        int n;
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.valid_in = 1'b0; bus.flush_in = 1'b0; bus.alu_op = '0;
        bus.alu_mode_select = '0; bus.reg_1_in = '0; bus.reg_2_in = '0;
        bus.imm_data_in = '0; bus.pc_ex = '0;
        rst_n = 1'b0;

        //   op     mode  r1            r2            imm           pc            expected
        add(5'd0,  2'd0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h80000000);
        add(5'd1,  2'd0, 32'd5,        32'd5,        32'h0,        32'h0,        32'h00000000);
        add(5'd0,  2'd2, 32'h0,        32'h0,        32'hFFFFFFF8, 32'h00000100, 32'h000000F8);
        add(5'd0,  2'd3, 32'h0,        32'h0,        32'hFFFFFFF8, 32'h00000100, 32'h00000104);
        add(5'd3,  2'd0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h00000001);
        add(5'd2,  2'd1, 32'h00000001, 32'h0,        32'h00000025, 32'h0,        32'h00000020);
        add(5'd6,  2'd0, 32'h80000000, 32'h00000024, 32'h0,        32'h0,        32'h08000000);
        add(5'd5,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        32'h0FF00FF0);
        add(5'd8,  2'd0, 32'h12340000, 32'h00005678, 32'h0,        32'h0,        32'h12345678);
        add(5'd9,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        32'hF000F000);
        add(5'd10, 2'd1, 32'h11111111, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF);
        add(5'd11, 2'd0, 32'h00000003, 32'h00000004, 32'h0,        32'h0,        32'h00000000);
        add(5'd31, 2'd0, 32'h00000003, 32'h00000004, 32'h0,        32'h0,        32'h00000000);
        addm(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        addm(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        addm(5'd16, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1);
        addm(5'd18, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        addm(5'd20, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        addm(5'd22, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        addm(5'd21, 32'd100,      32'd7,        32'd14);
        addm(5'd23, 32'd100,      32'd7,        32'd2);
        addm(5'd21, 32'd9,        32'd0,        32'hFFFFFFFF);
        addm(5'd23, 32'd9,        32'd0,        32'd9);
        addm(5'd20, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFFF);
        addm(5'd22, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7);
        addm(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        addm(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready_out), 32'd1);
        chk("rst_valid", 32'(bus.result_valid_out), 32'd0);
        chk("rst_result", bus.alu_result_out, 32'h0);
        chk("rst_zero", 32'(bus.alu_zero_out), 32'd1);
        chk("rst_busy", 32'(bus.busy_out), 32'd0);
        @(posedge clk); #1;

        foreach (tv[i]) send(tv[i], 1'b1);
        drain();

        // back-to-back base ops, ready must hold between them
        send(mk(5'd7, 32'h80000000, 32'd4, 32'hF8000000), 1'b1);
        chk("b2b_ready", 32'(bus.ready_out), 32'd1);
        send(mk(5'd4, 32'd1, 32'hFFFFFFFF, 32'd1), 1'b1);
        drain();

        // length of the not-ready window after an M op
        send(mk(5'd21, 32'd100, 32'd7, MEXT ? 32'd14 : 32'd0), 1'b1);
        chk("busy_flag", 32'(bus.busy_out), 32'(MEXT));
        n = 0;
        while (!bus.ready_out && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("not_ready_cycles", 32'(n), MEXT ? 32'(XLEN) : 32'd0);
        drain();

        // flush together with valid: request must not be accepted
        bus.alu_op = 5'd0; bus.alu_mode_select = 2'd0;
        bus.reg_1_in = 32'd40; bus.reg_2_in = 32'd2;
        bus.valid_in = 1'b1; bus.flush_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0; bus.flush_in = 1'b0;
        @(negedge clk);
        chk("flush_valid_pulse", 32'(bus.result_valid_out), 32'd0);
        chk("flush_valid_hold", bus.alu_result_out, last_res);
        @(posedge clk); #1;

        // flush in the cycle a base-op pulse would appear
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0; bus.flush_in = 1'b1;
        @(negedge clk);
        chk("flush_pulse", 32'(bus.result_valid_out), 32'd0);
        @(posedge clk); #1;
        bus.flush_in = 1'b0;
        send(mk(5'd0, 32'd40, 32'd2, 32'd42), 1'b1);
        drain();

`ifdef ALU_MEXT_EN
        // flush ten cycles into a divide: no result, old result held
        send(mk(5'd20, 32'd1000, 32'd3, 32'd333), 1'b0);
        repeat (10) @(posedge clk);
        #1 bus.flush_in = 1'b1;
        @(posedge clk); #1;
        bus.flush_in = 1'b0;
        chk("mflush_ready", 32'(bus.ready_out), 32'd1);
        chk("mflush_busy", 32'(bus.busy_out), 32'd0);
        chk("mflush_hold", bus.alu_result_out, last_res);
        chk("mflush_zero", 32'(bus.alu_zero_out), 32'(last_res == 32'h0));
        repeat (40) @(posedge clk);
        #1;

        // same with reset: outputs return to reset values
        send(mk(5'd20, 32'd1000, 32'd3, 32'd333), 1'b0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst_ready", 32'(bus.ready_out), 32'd1);
        chk("mrst_busy", 32'(bus.busy_out), 32'd0);
        chk("mrst_valid", 32'(bus.result_valid_out), 32'd0);
        chk("mrst_result", bus.alu_result_out, 32'h0);
        chk("mrst_zero", 32'(bus.alu_zero_out), 32'd1);
        last_res = '0;
        repeat (40) @(posedge clk);
        #1;
`endif

        // reset after a nonzero result clears the result registers
        send(mk(5'd8, 32'h00F0, 32'h0F00, 32'h0FF0), 1'b1);
        drain();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst2_result", bus.alu_result_out, 32'h0);
        chk("rst2_zero", 32'(bus.alu_zero_out), 32'd1);
        chk("rst2_valid", 32'(bus.result_valid_out), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
